irq_dispatch: RTL and testbench

IRQ_DISPATCH -- requirements
Module: irq_dispatch

---
 rtl/irq_dispatch_if.sv | 34 +++
 rtl/irq_dispatch.sv | 128 ++++++++++++
 tb/tb_irq_dispatch.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/irq_dispatch_if.sv
// Interrupt request/acknowledge bundle between the requester side and irq_dispatch.
//   req_bus  : bus-request flags (bit0 = bus A, bit1 = bus B, bit2 = bus C)
//   req_chan : encoded channel number from the priority decoder
//   mask     : per-bus disable, same bit order as req_bus (1 = ignore)
//   ack, eoi : CPU acknowledge / end-of-interrupt, level-sampled
//   irq      : interrupt request to the CPU
//   vec      : {lvl[1:0], chan[3:0]} of the latched request
//   vec_vld  : one-cycle strobe on acknowledge
//   busy     : interrupt in service
//   tmo      : one-cycle strobe on acknowledge timeout
interface irq_dispatch_if;
  logic [2:0] req_bus;
  logic [3:0] req_chan;
  logic [2:0] mask;
  logic       ack;
  logic       eoi;
  logic       irq;
  logic [5:0] vec;
  logic       vec_vld;
  logic       busy;
  logic       tmo;

  // Requester / CPU side.
  modport master (
    output req_bus, req_chan, mask, ack, eoi,
    input  irq, vec, vec_vld, busy, tmo
  );

  // Dispatcher side.
  modport slave (
    input  req_bus, req_chan, mask, ack, eoi,
    output irq, vec, vec_vld, busy, tmo
  );
endinterface

// File: rtl/irq_dispatch.sv
// Interrupt dispatcher: qualifies a prioritised bus request over QUAL_CYC identical
// samples, presents it to the CPU, tracks acknowledge/service, and abandons a request
// that is not acknowledged within TMO_CYC cycles.
//   clk    : single clock, rising edge
//   rst_n  : synchronous active-low reset
//   irq_if : irq_dispatch_if.slave (request inputs, CPU handshake, status outputs)
module irq_dispatch #(
  parameter int unsigned QUAL_CYC = 2,   // legal 2..15
  parameter int unsigned TMO_CYC  = 255  // legal 1..255
) (
  input  logic            clk,
  input  logic            rst_n,
  irq_dispatch_if.slave   irq_if
);

  localparam logic [3:0] QualLast = 4'(QUAL_CYC);
  localparam logic [7:0] TmoLast  = 8'(TMO_CYC - 1);

  typedef enum logic [1:0] {StIdle, StQual, StPend, StService} state_e;

  state_e     state_q, state_d;
  logic [3:0] qcnt_q, qcnt_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic [5:0] cand_q, cand_d;
  logic       vld_q, vld_d;
  logic       tmo_q, tmo_d;

  logic [2:0] eb;
  logic [1:0] lvl;
  logic [5:0] sample;
  logic [3:0] qcnt_inc;

  assign eb = irq_if.req_bus & ~irq_if.mask;

  // Lowest-numbered enabled bus wins; lvl 0 means no request.
  always_comb begin
    lvl = 2'd0;
    if (eb[0]) begin
      lvl = 2'd1;
    end else if (eb[1]) begin
      lvl = 2'd2;
    end else if (eb[2]) begin
      lvl = 2'd3;
    end
  end

  assign sample   = {lvl, irq_if.req_chan};
  assign qcnt_inc = qcnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    tcnt_d  = tcnt_q;
    cand_d  = cand_q;
    vld_d   = 1'b0;
    tmo_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (lvl != 2'd0) begin
          state_d = StQual;
          cand_d  = sample;
          qcnt_d  = 4'd1;
        end
      end
      StQual: begin
        if (lvl == 2'd0) begin
          state_d = StIdle;
        end else if (sample == cand_q) begin
          qcnt_d = qcnt_inc;
          if (qcnt_inc == QualLast) begin
            state_d = StPend;
            tcnt_d  = 8'd0;
          end
        end else begin
          // A different request restarts qualification on the new candidate.
          cand_d = sample;
          qcnt_d = 4'd1;
        end
      end
      StPend: begin
        // Acknowledge takes precedence over a timeout on the same edge.
        if (irq_if.ack) begin
          state_d = StService;
          vld_d   = 1'b1;
        end else if (tcnt_q == TmoLast) begin
          state_d = StIdle;
          tmo_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      StService: begin
        if (irq_if.eoi) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      qcnt_q  <= 4'd0;
      tcnt_q  <= 8'd0;
      cand_q  <= 6'h00;
      vld_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      tcnt_q  <= tcnt_d;
      cand_q  <= cand_d;
      vld_q   <= vld_d;
      tmo_q   <= tmo_d;
    end
  end

  // All outputs decode registered state only.
  assign irq_if.irq     = (state_q == StPend);
  assign irq_if.busy    = (state_q == StService);
  assign irq_if.vec     = ((state_q == StPend) || (state_q == StService)) ? cand_q : 6'h00;
  assign irq_if.vec_vld = vld_q;
  assign irq_if.tmo     = tmo_q;

endmodule

// File: tb/tb_irq_dispatch.sv
// Directed, table-driven bench for irq_dispatch. u_dut runs QUAL_CYC=2, TMO_CYC=4 against a
// vector table; u_q3 runs QUAL_CYC=3, TMO_CYC=2 through a short hand-written sequence.
module tb_irq_dispatch;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   checks;
  int   failures;

  irq_dispatch_if dif ();
  irq_dispatch_if qif ();

  irq_dispatch #(.QUAL_CYC(2), .TMO_CYC(4)) u_dut (
    .clk    (clk),
    .rst_n  (rst_a),
    .irq_if (dif)
  );

  irq_dispatch #(.QUAL_CYC(3), .TMO_CYC(2)) u_q3 (
    .clk    (clk),
    .rst_n  (rst_b),
    .irq_if (qif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst_n;
    logic [2:0] bus;
    logic [3:0] chan;
    logic [2:0] mask;
    logic       ack;
    logic       eoi;
    logic       irq;
    logic [5:0] vec;
    logic       vld;
    logic       busy;
    logic       tmo;
  } row_t;

  row_t tbl[$];

  task automatic add(input logic r, input logic [2:0] b, input logic [3:0] c,
                     input logic [2:0] m, input logic a, input logic e, input logic irq,
                     input logic [5:0] vec, input logic vld, input logic busy,
                     input logic tmo);
    row_t x;
    x.rst_n = r; x.bus = b; x.chan = c; x.mask = m; x.ack = a; x.eoi = e;
    x.irq = irq; x.vec = vec; x.vld = vld; x.busy = busy; x.tmo = tmo;
    tbl.push_back(x);
  endtask

  // Compared as {irq, vec[5:0], vec_vld, busy, tmo}.
  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got irq/vec/vld/busy/tmo=%b_%h_%b%b%b want %b_%h_%b%b%b", name,
               act[9], act[8:3], act[2], act[1], act[0],
               exp[9], exp[8:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive_q(input logic r, input logic [2:0] b, input logic [3:0] c);
    @(negedge clk);
    rst_b        = r;
    qif.req_bus  = b;
    qif.req_chan = c;
    @(posedge clk);
    #1;
  endtask

  logic [9:0] exp_q[8];

  initial begin
    checks   = 0;
    failures = 0;
    rst_a = 1'b0; rst_b = 1'b0;
    dif.req_bus = '0; dif.req_chan = '0; dif.mask = '0; dif.ack = 1'b0; dif.eoi = 1'b0;
    qif.req_bus = '0; qif.req_chan = '0; qif.mask = '0; qif.ack = 1'b0; qif.eoi = 1'b0;

    //   rst bus     chan  mask    ack eoi   irq vec    vld busy tmo
    add(0, 3'b000, 4'h0, 3'b000, 0, 0,   0, 6'h00, 0, 0, 0);  // reset
    add(0, 3'b000, 4'h0, 3'b000, 0, 0,   0, 6'h00, 0, 0, 0);
    add(1, 3'b010, 4'h5, 3'b000, 0, 0,   0, 6'h00, 0, 0, 0);  // first sample -> QUAL
    add(1, 3'b010, 4'h5, 3'b000, 0, 0,   1, 6'h25, 0, 0, 0);  // PEND
    add(1, 3'b010, 4'h5, 3'b000, 1, 0,   0, 6'h25, 1, 1, 0);  // ack -> SERVICE
    add(1, 3'b010, 4'h5, 3'b000, 0, 0,   0, 6'h25, 0, 1, 0);  // strobe ends
    add(1, 3'b000, 4'h0, 3'b000, 0, 1,   0, 6'h00, 0, 0, 0);  // eoi -> IDLE
    add(1, 3'b000, 4'h0, 3'b000, 1, 1,   0, 6'h00, 0, 0, 0);  // stray ack/eoi
    add(1, 3'b011, 4'h3, 3'b001, 0, 0,   0, 6'h00, 0, 0, 0);  // bus A masked
    add(1, 3'b011, 4'h3, 3'b001, 0, 0,   1, 6'h23, 0, 0, 0);
    add(1, 3'b011, 4'h3, 3'b001, 1, 0,   0, 6'h23, 1, 1, 0);
    add(1, 3'b000, 4'h0, 3'b000, 0, 1,   0, 6'h00, 0, 0, 0);
    add(1, 3'b011, 4'h3, 3'b001, 0, 0,   0, 6'h00, 0, 0, 0);  // QUAL cand 23
    add(1, 3'b011, 4'h3, 3'b000, 0, 0,   0, 6'h00, 0, 0, 0);  // unmask -> recapture 13
    add(1, 3'b011, 4'h3, 3'b000, 0, 0,   1, 6'h13, 0, 0, 0);
    add(1, 3'b011, 4'h3, 3'b000, 1, 1,   0, 6'h13, 1, 1, 0);  // eoi in PEND ignored
    add(1, 3'b011, 4'h3, 3'b000, 0, 1,   0, 6'h00, 0, 0, 0);  // leave SERVICE to IDLE
    add(1, 3'b011, 4'h3, 3'b000, 0, 0,   0, 6'h00, 0, 0, 0);  // IDLE samples -> QUAL
    add(1, 3'b000, 4'h0, 3'b000, 0, 0,   0, 6'h00, 0, 0, 0);  // drop -> IDLE
    add(1, 3'b100, 4'h7, 3'b000, 0, 0,   0, 6'h00, 0, 0, 0);  // one-cycle glitch
    add(1, 3'b000, 4'h0, 3'b000, 0, 0,   0, 6'h00, 0, 0, 0);
    add(1, 3'b000, 4'h0, 3'b000, 0, 0,   0, 6'h00, 0, 0, 0);
    add(1, 3'b111, 4'h2, 3'b111, 0, 0,   0, 6'h00, 0, 0, 0);  // everything masked
    add(1, 3'b111, 4'h2, 3'b111, 0, 0,   0, 6'h00, 0, 0, 0);
    add(1, 3'b100, 4'hA, 3'b000, 0, 0,   0, 6'h00, 0, 0, 0);  // cand 3A
    add(1, 3'b100, 4'hB, 3'b000, 0, 0,   0, 6'h00, 0, 0, 0);  // chan change -> 3B
    add(1, 3'b100, 4'hB, 3'b000, 0, 0,   1, 6'h3B, 0, 0, 0);  // PEND, tcnt 0
    add(1, 3'b001, 4'h1, 3'b000, 0, 0,   1, 6'h3B, 0, 0, 0);  // inputs ignored in PEND
    add(1, 3'b000, 4'h0, 3'b000, 0, 0,   1, 6'h3B, 0, 0, 0);
    add(1, 3'b000, 4'h0, 3'b000, 0, 0,   1, 6'h3B, 0, 0, 0);  // 4th IRQ cycle
    add(1, 3'b000, 4'h0, 3'b000, 0, 0,   0, 6'h00, 0, 0, 1);  // timeout strobe
    add(1, 3'b000, 4'h0, 3'b000, 0, 0,   0, 6'h00, 0, 0, 0);
    add(1, 3'b010, 4'h9, 3'b000, 0, 0,   0, 6'h00, 0, 0, 0);  // held request
    add(1, 3'b010, 4'h9, 3'b000, 0, 0,   1, 6'h29, 0, 0, 0);
    add(1, 3'b010, 4'h9, 3'b000, 0, 0,   1, 6'h29, 0, 0, 0);
    add(1, 3'b010, 4'h9, 3'b000, 0, 0,   1, 6'h29, 0, 0, 0);
    add(1, 3'b010, 4'h9, 3'b000, 0, 0,   1, 6'h29, 0, 0, 0);
    add(1, 3'b010, 4'h9, 3'b000, 0, 0,   0, 6'h00, 0, 0, 1);  // timeout
    add(1, 3'b010, 4'h9, 3'b000, 0, 0,   0, 6'h00, 0, 0, 0);  // re-qualify
    add(1, 3'b010, 4'h9, 3'b000, 0, 0,   1, 6'h29, 0, 0, 0);
    add(1, 3'b010, 4'h9, 3'b000, 0, 0,   1, 6'h29, 0, 0, 0);
    add(1, 3'b010, 4'h9, 3'b000, 0, 0,   1, 6'h29, 0, 0, 0);
    add(1, 3'b010, 4'h9, 3'b000, 0, 0,   1, 6'h29, 0, 0, 0);
    add(1, 3'b010, 4'h9, 3'b000, 1, 0,   0, 6'h29, 1, 1, 0);  // ack on timeout edge
    add(0, 3'b010, 4'h9, 3'b000, 0, 1,   0, 6'h00, 0, 0, 0);  // reset mid-SERVICE
    add(1, 3'b010, 4'h9, 3'b000, 0, 0,   0, 6'h00, 0, 0, 0);
    add(1, 3'b010, 4'h9, 3'b000, 0, 0,   1, 6'h29, 0, 0, 0);
    add(1, 3'b010, 4'h9, 3'b000, 0, 0,   1, 6'h29, 0, 0, 0);
    add(1, 3'b010, 4'h9, 3'b000, 0, 0,   1, 6'h29, 0, 0, 0);
    add(1, 3'b010, 4'h9, 3'b000, 0, 0,   1, 6'h29, 0, 0, 0);
    add(0, 3'b010, 4'h9, 3'b000, 0, 0,   0, 6'h00, 0, 0, 0);  // reset beats timeout
    add(1, 3'b000, 4'h0, 3'b000, 0, 0,   0, 6'h00, 0, 0, 0);
    add(1, 3'b111, 4'h2, 3'b000, 0, 0,   0, 6'h00, 0, 0, 0);  // bus A wins
    add(1, 3'b111, 4'h2, 3'b000, 0, 0,   1, 6'h12, 0, 0, 0);
    add(1, 3'b111, 4'h2, 3'b000, 1, 0,   0, 6'h12, 1, 1, 0);
    add(1, 3'b111, 4'h2, 3'b000, 1, 0,   0, 6'h12, 0, 1, 0);  // ack in SERVICE ignored
    add(1, 3'b000, 4'h0, 3'b000, 0, 1,   0, 6'h00, 0, 0, 0);
    add(1, 3'b110, 4'hF, 3'b010, 0, 0,   0, 6'h00, 0, 0, 0);  // only bus C enabled
    add(1, 3'b110, 4'hF, 3'b010, 0, 0,   1, 6'h3F, 0, 0, 0);
    add(0, 3'b110, 4'hF, 3'b010, 0, 0,   0, 6'h00, 0, 0, 0);  // reset mid-PEND

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_a        = tbl[i].rst_n;
      dif.req_bus  = tbl[i].bus;
      dif.req_chan = tbl[i].chan;
      dif.mask     = tbl[i].mask;
      dif.ack      = tbl[i].ack;
      dif.eoi      = tbl[i].eoi;
      @(posedge clk);
      #1;
      check($sformatf("row%0d", i),
            {dif.irq, dif.vec, dif.vec_vld, dif.busy, dif.tmo},
            {tbl[i].irq, tbl[i].vec, tbl[i].vld, tbl[i].busy, tbl[i].tmo});
    end

    // QUAL_CYC=3 latency, TMO_CYC=2 timeout and re-qualification with a held request.
    exp_q[0] = {1'b0, 6'h00, 3'b000};  // QUAL, qcnt 1
    exp_q[1] = {1'b0, 6'h00, 3'b000};  // qcnt 2
    exp_q[2] = {1'b1, 6'h14, 3'b000};  // PEND
    exp_q[3] = {1'b1, 6'h14, 3'b000};
    exp_q[4] = {1'b0, 6'h00, 3'b001};  // timeout
    exp_q[5] = {1'b0, 6'h00, 3'b000};
    exp_q[6] = {1'b0, 6'h00, 3'b000};
    exp_q[7] = {1'b1, 6'h14, 3'b000};
    drive_q(1'b0, 3'b000, 4'h0);
    check("q3_reset", {qif.irq, qif.vec, qif.vec_vld, qif.busy, qif.tmo}, 10'd0);
    for (int k = 0; k < 8; k++) begin
      drive_q(1'b1, 3'b001, 4'h4);
      check($sformatf("q3_step%0d", k),
            {qif.irq, qif.vec, qif.vec_vld, qif.busy, qif.tmo}, exp_q[k]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
